// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
//
// Holds the program counter and reads one 32-bit word per instruction from
// instruction memory over a req/ready port. Each word is offered to the decoder
// with the DOR / ack handshake. The PC advances only after the decoder drops its
// ack, because the decoder keeps ack high until it has finished executing.
//
// A redirect reloads the PC. In REQ it takes effect at once and the in-flight
// read is dropped. In PRESENT or RELEASE it is held as pending until the current
// word has been released, because a presented word is never retracted.
//
// Optional feature, enabled by defining the macro FETCH_HALT_EN:
//   A fetched MIPS `break` word (32'h0000_000D) is not presented. The stage
//   parks in a HALTED state instead, which only a redirect or reset can leave.
//   With the macro undefined the word is forwarded like any other word, and
//   `halted` is tied low.

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction memory read port
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  // Decoder handshake
  output logic        DOR,
  input  logic        ack_from_next,
  output logic [31:0] data_out,
  output logic [31:0] pc_out,
  // PC reload
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

`ifdef FETCH_HALT_EN
  localparam logic [31:0] BreakWord = 32'h0000_000D;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StPresent,
    StRelease,
    StHalted
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StPresent,
    StRelease
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_out_q, pc_out_d;

  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  // The low two address bits of a redirect are meaningless for word fetches.
  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // State register and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= ResetPcAligned;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0000_0000;
      data_q    <= 32'h0000_0000;
      pc_out_q  <= ResetPcAligned;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      data_q    <= data_d;
      pc_out_q  <= pc_out_d;
    end
  end

  // Next-state, PC sequencing and redirect bookkeeping.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    data_d    = data_q;
    pc_out_d  = pc_out_q;

    // Latch every redirect; states that apply it at once clear it again below.
    // A later redirect simply overwrites an earlier pending target.
    if (redirect) begin
      pend_d    = 1'b1;
      pend_pc_d = redirect_tgt;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        // No fetch is in flight yet, so a redirect here can be applied directly.
        if (redirect) begin
          pc_d   = redirect_tgt;
          pend_d = 1'b0;
        end
      end

      StReq: begin
        if (redirect) begin
          // Abandon the in-flight read; any mem_ready on this edge is dropped.
          pc_d   = redirect_tgt;
          pend_d = 1'b0;
        end else if (mem_ready) begin
`ifdef FETCH_HALT_EN
          if (mem_data == BreakWord) begin
            state_d = StHalted;
          end else begin
            data_d   = mem_data;
            pc_out_d = pc_q;
            state_d  = StPresent;
          end
`else
          data_d   = mem_data;
          pc_out_d = pc_q;
          state_d  = StPresent;
`endif
        end
      end

      StPresent: begin
        if (ack_from_next) begin
          state_d = StRelease;
        end
      end

      StRelease: begin
        if (!ack_from_next) begin
          state_d = StReq;
          pend_d  = 1'b0;
          // A redirect on the exit edge beats both the pending target and pc+4.
          if (redirect) begin
            pc_d = redirect_tgt;
          end else if (pend_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

`ifdef FETCH_HALT_EN
      StHalted: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          pend_d  = 1'b0;
          state_d = StReq;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the current state and registers.
  always_comb begin
    mem_req  = (state_q == StReq);
    mem_addr = pc_q;
    DOR      = (state_q == StPresent);
    data_out = data_q;
    pc_out   = pc_out_q;
`ifdef FETCH_HALT_EN
    halted   = (state_q == StHalted);
`else
    halted   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of fetch transactions plus a
// few hand-written sequences for redirect, reset, PC wrap and break handling.

module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req, mem_ready, dor, ack, redirect, halted;
  logic [31:0] mem_addr, mem_data, data_out, pc_out, redirect_pc;

  // Second instance checks the PC wrap from the top of the address space.
  logic        mem_req2, mem_ready2, dor2, ack2, halted2;
  logic [31:0] mem_addr2, mem_data2, data_out2, pc_out2;

  int          wait_cycles = 0;
  int          req_cnt = 0;
  logic        brk_on = 1'b0;
  logic [31:0] brk_addr = 32'h0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          overlap_cnt = 0;

  typedef struct {
    int          wait_c;
    int          ack_dly;
    int          hold;
    logic [31:0] addr;
  } fetch_t;

  fetch_t vec[5];

  instruction_fetch u_dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .DOR          (dor),
    .ack_from_next(ack),
    .data_out     (data_out),
    .pc_out       (pc_out),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
  );

  instruction_fetch #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req2),
    .mem_addr     (mem_addr2),
    .mem_ready    (mem_ready2),
    .mem_data     (mem_data2),
    .DOR          (dor2),
    .ack_from_next(ack2),
    .data_out     (data_out2),
    .pc_out       (pc_out2),
    .redirect     (1'b0),
    .redirect_pc  (32'h0),
    .halted       (halted2)
  );

  // Memory model: ready after wait_cycles consecutive request cycles.
  always @(posedge clk) req_cnt <= mem_req ? req_cnt + 1 : 0;
  assign mem_ready  = mem_req && (req_cnt >= wait_cycles);
  assign mem_data   = (brk_on && mem_addr == brk_addr) ? 32'h0000_000D
                                                       : (mem_addr ^ 32'hA5A5_0000);
  assign mem_ready2 = mem_req2;
  assign mem_data2  = mem_addr2 ^ 32'hA5A5_0000;

  always @(negedge clk) if (!reset && dor && mem_req) overlap_cnt <= overlap_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !mem_req; i++) step();
  endtask

  task automatic fetch_one(input fetch_t v, input int idx);
    int   lat;
    logic held;
    logic quiet;
    wait_cycles = v.wait_c;
    wait_req();
    chk($sformatf("v%0d_req", idx), {31'b0, mem_req}, 32'd1);
    chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
    held = 1'b1;
    lat  = 0;
    while (!dor && lat < 50) begin
      if (mem_req && mem_addr !== v.addr) held = 1'b0;
      step();
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.wait_c + 1);
    chk($sformatf("v%0d_addr_held", idx), {31'b0, held}, 32'd1);
    chk($sformatf("v%0d_data", idx), data_out, v.addr ^ 32'hA5A5_0000);
    chk($sformatf("v%0d_pc_out", idx), pc_out, v.addr);
    repeat (v.ack_dly) step();
    chk($sformatf("v%0d_dor_hold", idx), {31'b0, dor}, 32'd1);
    ack = 1'b1;
    step();
    chk($sformatf("v%0d_dor_fall", idx), {31'b0, dor}, 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      if (mem_req) quiet = 1'b0;
      step();
    end
    if (mem_req) quiet = 1'b0;
    chk($sformatf("v%0d_no_req_while_ack", idx), {31'b0, quiet}, 32'd1);
    ack = 1'b0;
    step();
    chk($sformatf("v%0d_req_after_release", idx), {31'b0, mem_req}, 32'd1);
  endtask

  initial begin
    vec[0] = '{0, 2, 1, 32'h0000_0000};
    vec[1] = '{3, 2, 1, 32'h0000_0004};
    vec[2] = '{0, 0, 10, 32'h0000_0008};
    vec[3] = '{1, 1, 0, 32'h0000_000C};
    vec[4] = '{0, 2, 1, 32'h0000_0010};

    reset = 1'b1;
    ack = 1'b0;
    ack2 = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    chk("rst_dor", {31'b0, dor}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_wrap_addr", mem_addr2, 32'hFFFF_FFFC);
    chk("rst_wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    reset = 1'b0;
    chk("idle_no_req", {31'b0, mem_req}, 32'd0);
    step();
    chk("req_after_idle", {31'b0, mem_req}, 32'd1);

    for (int i = 0; i < 5; i++) fetch_one(vec[i], i);

    // Redirect during PRESENT: current word completes, then jump.
    wait_cycles = 0;
    wait_req();
    chk("rp_addr", mem_addr, 32'h14);
    step();
    chk("rp_dor", {31'b0, dor}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    chk("rp_dor_kept", {31'b0, dor}, 32'd1);
    chk("rp_pc_out_kept", pc_out, 32'h14);
    chk("rp_data_kept", data_out, 32'h14 ^ 32'hA5A5_0000);
    ack = 1'b1;
    step();
    chk("rp_dor_fall", {31'b0, dor}, 32'd0);
    ack = 1'b0;
    wait_cycles = 2;
    step();
    chk("rp_req", {31'b0, mem_req}, 32'd1);
    chk("rp_target", mem_addr, 32'h100);

    // Ack already high when PRESENT is entered: accepted on the first edge.
    ack = 1'b1;
    for (int i = 0; i < 50 && !dor; i++) step();
    chk("early_ack_dor", {31'b0, dor}, 32'd1);
    chk("early_ack_pc", pc_out, 32'h100);
    step();
    chk("early_ack_dor_fall", {31'b0, dor}, 32'd0);
    ack = 1'b0;
    wait_cycles = 0;
    step();
    chk("early_ack_next_addr", mem_addr, 32'h104);

    // Redirect in REQ on the same edge as mem_ready: the read is discarded.
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("rq_no_dor", {31'b0, dor}, 32'd0);
    chk("rq_req", {31'b0, mem_req}, 32'd1);
    chk("rq_addr", mem_addr, 32'h200);
    step();
    chk("rq_dor", {31'b0, dor}, 32'd1);
    chk("rq_pc_out", pc_out, 32'h200);
    chk("rq_data", data_out, 32'h200 ^ 32'hA5A5_0000);

    // Two redirects during RELEASE: the later one wins.
    ack = 1'b1;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h405;
    step();
    redirect = 1'b0;
    ack = 1'b0;
    brk_on = 1'b1;
    brk_addr = 32'h404;
    step();
    chk("rr_req", {31'b0, mem_req}, 32'd1);
    chk("rr_addr", mem_addr, 32'h404);

`ifdef FETCH_HALT_EN
    step();
    chk("brk_halted", {31'b0, halted}, 32'd1);
    chk("brk_no_dor", {31'b0, dor}, 32'd0);
    chk("brk_no_req", {31'b0, mem_req}, 32'd0);
    repeat (3) step();
    chk("brk_still_halted", {31'b0, halted}, 32'd1);
    chk("brk_still_no_dor", {31'b0, dor}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    chk("brk_unhalt", {31'b0, halted}, 32'd0);
    chk("brk_req", {31'b0, mem_req}, 32'd1);
    chk("brk_addr", mem_addr, 32'h20);
    step();
    chk("brk_resume_data", data_out, 32'h20 ^ 32'hA5A5_0000);
`else
    step();
    chk("brk_fwd_dor", {31'b0, dor}, 32'd1);
    chk("brk_fwd_data", data_out, 32'h0000_000D);
    chk("brk_fwd_pc", pc_out, 32'h404);
    chk("brk_fwd_halted", {31'b0, halted}, 32'd0);
`endif
    brk_on = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();

    // Reset in the middle of a REQ with a slow memory.
    wait_cycles = 5;
    step();
    chk("mid_rst_in_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_dor", {31'b0, dor}, 32'd0);
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    wait_cycles = 0;

    // PC wrap from 0xFFFF_FFFC to 0.
    step();
    chk("wrap_first_addr", mem_addr2, 32'hFFFF_FFFC);
    step();
    chk("wrap_dor", {31'b0, dor2}, 32'd1);
    chk("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
    step();
    chk("wrap_req", {31'b0, mem_req2}, 32'd1);
    chk("wrap_second_addr", mem_addr2, 32'h0);

    chk("dor_req_overlap", overlap_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end pipeline stage: holds the program counter, reads 32-bit instruction words from instruction memory over a simple request/ready port, and presents each word to the downstream instruction decoder. The output handshake uses the decoder's DOR / ack convention. The block sits directly upstream of the decoder, and its `DOR` output drives the decoder's `DIR` input. An external redirect port (branch/jump unit, debug) reloads the PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; bits [1:0] are ignored (forced to 0).

Ports:
- `clk` input 1: single clock; everything samples on the rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_req` output 1: instruction memory read request.
- `mem_addr` output 32: word-aligned read address; valid while `mem_req`=1.
- `mem_ready` input 1: `mem_data` is valid this cycle; it is only meaningful while `mem_req`=1.
- `mem_data` input 32: instruction word.
- `DOR` output 1: `data_out` is valid for the next stage.
- `ack_from_next` input 1: acknowledge from the decoder (its `ack_prev`).
- `data_out` output 32: instruction word.
- `pc_out` output 32: address of the word on `data_out`.
- `redirect` input 1: load a new PC.
- `redirect_pc` input 32: new PC; bits [1:0] are ignored.
- `halted` output 1: fetch halted (see Configuration).

## Operation
States:
- IDLE:
  - Entered on reset. Lasts exactly one cycle, then goes to REQ.
- REQ:
  - Drives `mem_req`=1 and `mem_addr`=pc.
  - On an edge where `mem_ready`=1: `data_out`<=`mem_data`, `pc_out`<=pc, go to PRESENT.
- PRESENT:
  - Holds `DOR`=1, with `data_out` and `pc_out` stable.
  - On an edge where `ack_from_next`=1: `DOR`<=0, go to RELEASE.
- RELEASE:
  - Waits for `ack_from_next`=0. The decoder holds its ack high until it finishes executing, so the next word must not be offered earlier.
  - On that edge: pc<=pc+4, or the pending redirect target if one is pending, then go to REQ.
- HALTED: only exists when FETCH_HALT_EN is defined.

Redirect:
- `redirect`=1 on any edge outside reset latches `{redirect_pc[31:2],2'b00}` as pending.
  - In REQ, the redirect takes effect immediately: the pc is reloaded, the in-flight request is abandoned, and the block stays in REQ with the new address from the next cycle. Any `mem_ready` on that same edge is discarded.
  - In PRESENT or RELEASE, the current word still completes its handshake, because a presented word is never retracted. The pending target is applied at RELEASE exit.
- A redirect and a pc increment on the same edge: the redirect wins.
- A later redirect overwrites an earlier pending one.

Arithmetic: the PC is 32-bit unsigned and wraps, so 32'hFFFF_FFFC+4 gives 32'h0000_0000.

Reset mid-operation:
- Any state returns to IDLE.
- The pending redirect is cleared.
- All outputs take their reset values on the next edge.

## Timing
- Reset values:
  - `DOR`=0, `mem_req`=0, `halted`=0.
  - `data_out`=0.
  - `mem_addr`=`pc_out`=`RESET_PC`.
- Reset deasserted before edge N: IDLE is left at edge N, and `mem_req`=1 is visible from edge N+1.
- Memory latency: zero-wait memory (`mem_ready` in the first REQ cycle) gives `DOR`=1 one cycle after `mem_req` rises. Each extra wait cycle adds one cycle.
- Acknowledge: `ack_from_next` sampled high ⇒ `DOR` low the next cycle.
- Release: `ack_from_next` sampled low in RELEASE ⇒ `mem_req` high the next cycle.
- Minimum throughput is 3 cycles per instruction (REQ, PRESENT, RELEASE). `mem_req` is never high while `DOR`=1.
- If `ack_from_next` is already high when PRESENT is entered, it is accepted on that first PRESENT edge.

## Configuration
`FETCH_HALT_EN`:
- Defined:
  - A fetched word equal to 32'h0000_000D (MIPS `break`) is not presented. The block enters HALTED instead.
  - In HALTED: `halted`=1, `mem_req`=0, `DOR`=0.
  - HALTED is left only on `reset` (goes to IDLE) or on `redirect`. On redirect the pc is reloaded, `halted`<=0, and the block goes to REQ.
- Undefined:
  - The HALTED state does not exist, and `halted` is tied to 0.
  - 32'h0000_000D is forwarded like any other word.

## Test plan
- Zero-wait memory returning mem[a]=a^32'hA5A5_0000, with the decoder acking 2 cycles after `DOR` and releasing 1 cycle later ⇒ `data_out` sequence matches addresses 0, 4, 8, …; `pc_out` matches; no `DOR` while `mem_req`=1.
- `mem_ready` delayed 3 cycles ⇒ `mem_addr` holds 0x4 through the wait; `DOR` rises exactly 1 cycle after `mem_ready`.
- `ack_from_next` held high for 10 cycles after `DOR` falls ⇒ `mem_req` stays 0 until the cycle after ack falls.
- `redirect` with `redirect_pc`=0x103 during PRESENT at pc=0x8 ⇒ word 0x8 completes its handshake, and the next `mem_addr` is 0x100 (not 0xC).
- `RESET_PC`=32'hFFFF_FFFC ⇒ the second fetch address is 0x0. A reset asserted during REQ ⇒ `mem_req`=0 and `mem_addr`=`RESET_PC` on the next cycle.
- With FETCH_HALT_EN, mem[0x8]=0x0000000D ⇒ words 0 and 4 are presented, then `halted`=1 with `DOR` never raised for 0x8. A subsequent redirect to 0x20 ⇒ `halted`=0 and `mem_addr`=0x20.
